// File: rtl/lsu_dpi.sv
// lsu_dpi: load/store unit between execute and the DPI data memory port.
// Optional misalignment trap: define LSU_MISALIGN_CHECK_EN.
module lsu_dpi #(
   parameter int XLEN    = 64,
   parameter int ADDR_W  = 64,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [1:0]          req_size,
   input  logic                req_unsigned,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [XLEN-1:0]     resp_rdata,
   output logic                resp_err,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN-1:0]     mem_wdata,
   output logic [XLEN/8-1:0]   mem_wmask,
   input  logic                mem_resp_valid,
   input  logic [XLEN-1:0]     mem_rdata
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int TW    = $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t state_q, state_d;

   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [3:0]        bytes_in;
   logic [OFF_W-1:0]  amask;
   logic [OFF_W-1:0]  off_in;
   logic [OFF_W-1:0]  off_al;
   logic              mis;
   logic              size_err;
   logic              bad_in;
   logic              accept;
   logic              tmo;

   assign bytes_in = 4'd1 << req_size;
   assign amask    = OFF_W'(bytes_in - 4'd1);
   assign off_in   = req_addr[OFF_W-1:0];
   assign size_err = (XLEN == 32) && (req_size == 2'd3);
   assign accept   = req_valid && (state_q == S_IDLE);
   assign tmo      = (timer_q == TW'(TIMEOUT - 1));

`ifdef LSU_MISALIGN_CHECK_EN
   assign mis    = |(off_in & amask);
   assign off_al = off_in;
`else
   assign mis    = 1'b0;
   assign off_al = off_in & ~amask;
`endif

   assign bad_in = size_err || mis;

   // Lane extraction and sign/zero extension of the returned word
   logic [XLEN-1:0] ld_sh;
   logic [XLEN-1:0] ld_mask;
   logic [XLEN-1:0] ld_ext;
   logic [7:0]      nbits;
   logic            ld_sign;

   always_comb begin
      nbits   = 8'd8 << size_q;
      ld_sh   = mem_rdata >> {off_q, 3'b000};
      ld_mask = ~({XLEN{1'b1}} << nbits);
      ld_sign = |(ld_sh & ld_mask & ~(ld_mask >> 1));
      ld_ext  = (ld_sh & ld_mask)
              | ((ld_sign && !uns_q) ? ~ld_mask : '0);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (req_valid) state_d = bad_in ? S_RESP : S_REQ;
         S_REQ:  if (mem_req_ready) state_d = S_WAIT;
         S_WAIT: if (mem_resp_valid || tmo) state_d = S_RESP;
         S_RESP: if (resp_ready) state_d = S_IDLE;
      endcase
   end

   // Handshake outputs are pure state decodes
   always_comb begin
      req_ready     = (state_q == S_IDLE);
      mem_req_valid = (state_q == S_REQ);
      resp_valid    = (state_q == S_RESP);
   end

   // Request latch, wait timer and response capture
   always_comb begin
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      off_d   = off_q;
      wdata_d = wdata_q;
      timer_d = timer_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               we_d    = req_we;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               off_d   = off_al;
               wdata_d = req_wdata;
               rdata_d = '0;
               err_d   = bad_in;
            end
         end
         S_REQ: timer_d = '0;
         S_WAIT: begin
            timer_d = timer_q + TW'(1);
            if (mem_resp_valid) begin
               rdata_d = we_q ? '0 : ld_ext;
               err_d   = 1'b0;
            end else if (tmo) begin
               rdata_d = '0;
               err_d   = 1'b1;
            end
         end
         S_RESP: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         off_q   <= '0;
         wdata_q <= '0;
         timer_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         off_q   <= off_d;
         wdata_q <= wdata_d;
         timer_q <= timer_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Memory-side lanes derived from the latched request only
   always_comb begin
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q << {off_q, 3'b000};
      mem_wmask = we_q
                ? (~({NB{1'b1}} << (4'd1 << size_q)) << off_q)
                : '0;
      resp_rdata = rdata_q;
      resp_err   = err_q;
   end

endmodule
